// File: rtl/periph_target_pkg.sv
// -----------------------------------------------------------------------------
// periph_target_pkg
//   Shared types and constants for the peripheral target adapter:
//     - state_t   : adapter FSM states (IDLE, ACCESS, RESP)
//     - DEC_*     : position of the word-index field inside the 1 KiB window
//     - OPC_*     : response opcode encoding (0 = ok, 1 = error)
//     - is_mapped : decode helper, true when a word index hits a mapped register
// -----------------------------------------------------------------------------
package periph_target_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Word index inside the 1 KiB window: byte address bits [9:2].
  localparam int DEC_LSB   = 2;
  localparam int DEC_MSB   = 9;
  localparam int DEC_WIDTH = DEC_MSB - DEC_LSB + 1;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  function automatic logic is_mapped(input logic [DEC_WIDTH-1:0] idx,
                                     input int                   num_regs);
    return 32'(idx) < 32'(num_regs);
  endfunction

endpackage

// File: rtl/periph_target_timeout.sv
// -----------------------------------------------------------------------------
// periph_target_timeout
//   Loadable saturating cycle counter used to bound how long the adapter waits
//   for a register-bus acknowledge.
//
//   Ports:
//     clk        in   clock
//     rst        in   asynchronous active-high reset
//     clr        in   synchronous clear to 0
//     en         in   count enable (one increment per enabled cycle)
//     load       in   synchronous load of load_value (highest priority)
//     load_value in   value loaded when load is high
//     expire     out  high when enabled while the count sits at TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module periph_target_timeout #(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 expire
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count;

  // The final waiting cycle is the one in which the count already equals LAST,
  // so a timeout of N gives exactly N enabled cycles before expiry.
  assign expire = en && (count == LAST);

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count < LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/periph_target_adapter.sv
// -----------------------------------------------------------------------------
// periph_target_adapter
//   Responder end of the cluster peripheral req/gnt/r_valid protocol. Each
//   granted request is turned into one access on an ack-based register bus and
//   answered with exactly one in-order response. Unmapped or timed-out accesses
//   answer with an error opcode and zero data.
//
//   Core side:
//     data_req_i / data_gnt_o          request / combinational grant
//     data_add_i                       byte address, only [9:2] decoded
//     data_wen_i                       1 = read, 0 = write
//     data_wdata_i / data_be_i         write data / byte enables
//     data_r_valid_o                   one-cycle response strobe
//     data_r_rdata_o / data_r_opc_o    response data / 1 = error
//   Register side:
//     reg_req_o                        access request, held until ack
//     reg_add_o / reg_wen_o            word index / 1 = read
//     reg_wdata_o / reg_be_o           write data / byte enables
//     reg_ack_i                        access complete
//     reg_rdata_i / reg_err_i          read data / slave error, valid with ack
// -----------------------------------------------------------------------------
module periph_target_adapter
  import periph_target_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int BE_WIDTH       = DATA_WIDTH / 8,
  parameter  int NUM_REGS       = 16,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int REG_ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_i,
  // core side
  input  logic                      data_req_i,
  input  logic [ADDR_WIDTH-1:0]     data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic                      data_r_opc_o,
  // register bus side
  output logic                      reg_req_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_add_o,
  output logic                      reg_wen_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic [BE_WIDTH-1:0]       reg_be_o,
  input  logic                      reg_ack_i,
  input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
  input  logic                      reg_err_i
);

  state_t               state;
  logic [DEC_WIDTH-1:0] word_idx;
  logic                 mapped;
  logic                 in_access;
  logic                 timeout_expire;

  assign word_idx  = data_add_i[DEC_MSB:DEC_LSB];
  assign mapped    = is_mapped(word_idx, NUM_REGS);
  assign in_access = (state == ACCESS);

  // Only the word-index field takes part in decode; the rest of the address
  // is intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_add_i[ADDR_WIDTH-1:DEC_MSB+1],
                              data_add_i[DEC_LSB-1:0]};

  // Grant is combinational so a request issued in IDLE or alongside a response
  // is accepted in the same cycle. It is masked during reset so that every
  // output reads 0 while rst_i is high.
  assign data_gnt_o = data_req_i && !in_access && !rst_i;

  periph_target_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst_i),
    .clr        (!in_access || reg_ack_i),
    .en         (in_access && !reg_ack_i),
    .load       (data_gnt_o && mapped),
    .load_value ('0),
    .expire     (timeout_expire)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      data_r_valid_o <= 1'b0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= OPC_OK;
      reg_req_o      <= 1'b0;
      reg_add_o      <= '0;
      reg_wen_o      <= 1'b0;
      reg_wdata_o    <= '0;
      reg_be_o       <= '0;
    end else begin
      // Response strobe is one cycle unless a new response is produced below.
      data_r_valid_o <= 1'b0;

      unique case (state)
        IDLE, RESP: begin
          if (data_gnt_o) begin
            if (mapped) begin
              state       <= ACCESS;
              reg_req_o   <= 1'b1;
              reg_add_o   <= word_idx[REG_ADDR_WIDTH-1:0];
              reg_wen_o   <= data_wen_i;
              reg_wdata_o <= data_wdata_i;
              reg_be_o    <= data_be_i;
            end else begin
              // Unmapped: answer next cycle without touching the register bus.
              state          <= RESP;
              data_r_valid_o <= 1'b1;
              data_r_rdata_o <= '0;
              data_r_opc_o   <= OPC_ERR;
            end
          end else begin
            state <= IDLE;
          end
        end

        ACCESS: begin
          // An ack in the last allowed cycle takes precedence over the timeout.
          if (reg_ack_i) begin
            state          <= RESP;
            reg_req_o      <= 1'b0;
            data_r_valid_o <= 1'b1;
            data_r_rdata_o <= reg_wen_o ? reg_rdata_i : '0;
            data_r_opc_o   <= reg_err_i;
          end else if (timeout_expire) begin
            state          <= RESP;
            reg_req_o      <= 1'b0;
            data_r_valid_o <= 1'b1;
            data_r_rdata_o <= '0;
            data_r_opc_o   <= OPC_ERR;
          end
        end

        default: begin
          state     <= IDLE;
          reg_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_target_adapter.sv
// -----------------------------------------------------------------------------
// tb_periph_target_adapter
//   Directed bench for periph_target_adapter with NUM_REGS=16 and
//   TIMEOUT_CYCLES=4. Inputs change 2 time units after a rising edge; outputs
//   are sampled 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_periph_target_adapter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int NR  = 16;
  localparam int TO  = 4;
  localparam int RAW = 4;

  logic           clk;
  logic           rst_i;
  logic           data_req_i;
  logic [AW-1:0]  data_add_i;
  logic           data_wen_i;
  logic [DW-1:0]  data_wdata_i;
  logic [BW-1:0]  data_be_i;
  logic           data_gnt_o;
  logic           data_r_valid_o;
  logic [DW-1:0]  data_r_rdata_o;
  logic           data_r_opc_o;
  logic           reg_req_o;
  logic [RAW-1:0] reg_add_o;
  logic           reg_wen_o;
  logic [DW-1:0]  reg_wdata_o;
  logic [BW-1:0]  reg_be_o;
  logic           reg_ack_i;
  logic [DW-1:0]  reg_rdata_i;
  logic           reg_err_i;

  int checks = 0;
  int errors = 0;

  periph_target_adapter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BE_WIDTH       (BW),
    .NUM_REGS       (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .reg_req_o      (reg_req_o),
    .reg_add_o      (reg_add_o),
    .reg_wen_o      (reg_wen_o),
    .reg_wdata_o    (reg_wdata_o),
    .reg_be_o       (reg_be_o),
    .reg_ack_i      (reg_ack_i),
    .reg_rdata_i    (reg_rdata_i),
    .reg_err_i      (reg_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 2 units after the next rising edge.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] be);
    data_req_i   = req;
    data_add_i   = addr;
    data_wen_i   = wen;
    data_wdata_i = wdata;
    data_be_i    = be;
  endtask

  task automatic slave(input logic ack, input logic [31:0] rdata, input logic err);
    reg_ack_i   = ack;
    reg_rdata_i = rdata;
    reg_err_i   = err;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b1, 32'h0000_0008, 1'b1, 32'h0, 4'h0);
    slave(1'b0, 32'h0, 1'b0);

    // ---------------- reset state ----------------
    next();
    #1;
    check("rst_gnt",     32'(data_gnt_o),     32'd0);
    check("rst_rvalid",  32'(data_r_valid_o), 32'd0);
    check("rst_rdata",   data_r_rdata_o,      32'd0);
    check("rst_opc",     32'(data_r_opc_o),   32'd0);
    check("rst_reqo",    32'(reg_req_o),      32'd0);
    check("rst_add",     32'(reg_add_o),      32'd0);
    check("rst_wdata",   reg_wdata_o,         32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    next();
    rst_i = 1'b0;
    next();

    // ---------------- mapped read, immediate ack ----------------
    drive(1'b1, 32'h1020_4008, 1'b1, 32'h0, 4'hF);
    #1;
    check("rd_gnt_T",    32'(data_gnt_o),     32'd1);
    check("rd_reqo_T",   32'(reg_req_o),      32'd0);
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    slave(1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("rd_reqo_T1",  32'(reg_req_o),      32'd1);
    check("rd_add_T1",   32'(reg_add_o),      32'd2);
    check("rd_wen_T1",   32'(reg_wen_o),      32'd1);
    check("rd_rv_T1",    32'(data_r_valid_o), 32'd0);
    next();
    slave(1'b0, 32'h0, 1'b0);
    #1;
    check("rd_rv_T2",    32'(data_r_valid_o), 32'd1);
    check("rd_rdata_T2", data_r_rdata_o,      32'hDEAD_BEEF);
    check("rd_opc_T2",   32'(data_r_opc_o),   32'd0);
    check("rd_reqo_T2",  32'(reg_req_o),      32'd0);
    next();
    #1;
    check("rd_rv_T3",    32'(data_r_valid_o), 32'd0);

    // ---------------- mapped write, ack in 3rd ACCESS cycle ----------------
    drive(1'b1, 32'h0000_0014, 1'b0, 32'h1234_5678, 4'b0011);
    #1;
    check("wr_gnt",      32'(data_gnt_o),     32'd1);
    for (int i = 0; i < 3; i++) begin
      next();
      // Request kept high in the first two ACCESS cycles to prove gnt stays low.
      drive(i < 2, 32'h0000_0014, 1'b0, 32'h1234_5678, 4'b0011);
      slave(i == 2, 32'hFFFF_FFFF, 1'b0);
      #1;
      check($sformatf("wr_reqo_%0d", i),  32'(reg_req_o),      32'd1);
      check($sformatf("wr_add_%0d", i),   32'(reg_add_o),      32'd5);
      check($sformatf("wr_wen_%0d", i),   32'(reg_wen_o),      32'd0);
      check($sformatf("wr_wdata_%0d", i), reg_wdata_o,         32'h1234_5678);
      check($sformatf("wr_be_%0d", i),    32'(reg_be_o),       32'h3);
      check($sformatf("wr_gnt_%0d", i),   32'(data_gnt_o),     32'd0);
      check($sformatf("wr_rv_%0d", i),    32'(data_r_valid_o), 32'd0);
    end
    next();
    slave(1'b0, 32'h0, 1'b0);
    #1;
    check("wr_rv",       32'(data_r_valid_o), 32'd1);
    check("wr_rdata",    data_r_rdata_o,      32'd0);
    check("wr_opc",      32'(data_r_opc_o),   32'd0);
    check("wr_reqo_off", 32'(reg_req_o),      32'd0);
    next();

    // ---------------- unmapped access ----------------
    drive(1'b1, 32'h0000_03FC, 1'b1, 32'h0, 4'hF);
    #1;
    check("um_gnt",      32'(data_gnt_o),     32'd1);
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check("um_rv",       32'(data_r_valid_o), 32'd1);
    check("um_opc",      32'(data_r_opc_o),   32'd1);
    check("um_rdata",    data_r_rdata_o,      32'd0);
    check("um_reqo",     32'(reg_req_o),      32'd0);
    next();
    #1;
    check("um_rv_off",   32'(data_r_valid_o), 32'd0);
    check("um_reqo2",    32'(reg_req_o),      32'd0);

    // ---------------- timeout without ack ----------------
    drive(1'b1, 32'h0000_0004, 1'b1, 32'h0, 4'hF);
    slave(1'b0, 32'h5555_5555, 1'b0);
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < TO; i++) begin
      #1;
      check($sformatf("to_reqo_%0d", i), 32'(reg_req_o),      32'd1);
      check($sformatf("to_rv_%0d", i),   32'(data_r_valid_o), 32'd0);
      next();
    end
    #1;
    check("to_rv",       32'(data_r_valid_o), 32'd1);
    check("to_opc",      32'(data_r_opc_o),   32'd1);
    check("to_rdata",    data_r_rdata_o,      32'd0);
    check("to_reqo_off", 32'(reg_req_o),      32'd0);
    next();

    // ---------------- ack on the 4th cycle beats the timeout ----------------
    drive(1'b1, 32'h0000_0004, 1'b1, 32'h0, 4'hF);
    slave(1'b0, 32'h0, 1'b0);
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    next();
    next();
    next();
    slave(1'b1, 32'hA5A5_A5A5, 1'b0);
    #1;
    check("ackw_reqo4",  32'(reg_req_o),      32'd1);
    next();
    slave(1'b0, 32'h0, 1'b0);
    #1;
    check("ackw_rv",     32'(data_r_valid_o), 32'd1);
    check("ackw_opc",    32'(data_r_opc_o),   32'd0);
    check("ackw_rdata",  data_r_rdata_o,      32'hA5A5_A5A5);
    next();

    // ---------------- back-to-back mapped reads ----------------
    slave(1'b1, 32'h0000_0300, 1'b0);
    drive(1'b1, 32'h0000_000C, 1'b1, 32'h0, 4'hF);  // word 3
    #1;
    check("b2b_gnt0",    32'(data_gnt_o),     32'd1);
    next();
    drive(1'b1, 32'h0000_0010, 1'b1, 32'h0, 4'hF);  // word 4 pending
    #1;
    check("b2b_gnt1",    32'(data_gnt_o),     32'd0);
    check("b2b_add1",    32'(reg_add_o),      32'd3);
    next();
    slave(1'b1, 32'h0000_0400, 1'b0);
    #1;
    check("b2b_rv2",     32'(data_r_valid_o), 32'd1);
    check("b2b_rd2",     data_r_rdata_o,      32'h0000_0300);
    check("b2b_gnt2",    32'(data_gnt_o),     32'd1);
    next();
    drive(1'b1, 32'h0000_0018, 1'b1, 32'h0, 4'hF);  // word 6 pending
    #1;
    check("b2b_add3",    32'(reg_add_o),      32'd4);
    check("b2b_rv3",     32'(data_r_valid_o), 32'd0);
    next();
    slave(1'b1, 32'h0000_0600, 1'b0);
    #1;
    check("b2b_rv4",     32'(data_r_valid_o), 32'd1);
    check("b2b_rd4",     data_r_rdata_o,      32'h0000_0400);
    check("b2b_gnt4",    32'(data_gnt_o),     32'd1);
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check("b2b_add5",    32'(reg_add_o),      32'd6);
    next();
    slave(1'b0, 32'h0, 1'b0);
    #1;
    check("b2b_rv6",     32'(data_r_valid_o), 32'd1);
    check("b2b_rd6",     data_r_rdata_o,      32'h0000_0600);
    next();
    #1;
    check("b2b_rv7",     32'(data_r_valid_o), 32'd0);

    // ---------------- back-to-back unmapped ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_0100 + 32'(i * 4), 1'b1, 32'h0, 4'hF);
      #1;
      check($sformatf("bum_gnt_%0d", i), 32'(data_gnt_o), 32'd1);
      next();
      #1;
      check($sformatf("bum_rv_%0d", i),   32'(data_r_valid_o), 32'd1);
      check($sformatf("bum_opc_%0d", i),  32'(data_r_opc_o),   32'd1);
      check($sformatf("bum_reqo_%0d", i), 32'(reg_req_o),      32'd0);
      #(-1 + 1);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    next();
    #1;
    check("bum_rv_off",  32'(data_r_valid_o), 32'd0);

    // ---------------- reset during ACCESS ----------------
    drive(1'b1, 32'h0000_001C, 1'b1, 32'h0, 4'hF);  // word 7
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check("rsta_reqo",   32'(reg_req_o),      32'd1);
    rst_i = 1'b1;
    slave(1'b1, 32'h7777_7777, 1'b0);
    #1;
    check("rsta_reqo0",  32'(reg_req_o),      32'd0);
    check("rsta_rv0",    32'(data_r_valid_o), 32'd0);
    next();
    rst_i = 1'b0;
    slave(1'b0, 32'h0, 1'b0);
    #1;
    check("rsta_rv1",    32'(data_r_valid_o), 32'd0);
    next();
    #1;
    check("rsta_rv2",    32'(data_r_valid_o), 32'd0);
    drive(1'b1, 32'h0000_0008, 1'b1, 32'h0, 4'hF);
    #1;
    check("rsta_gnt",    32'(data_gnt_o),     32'd1);
    next();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    slave(1'b1, 32'h0BAD_F00D, 1'b0);
    #1;
    check("rsta_add",    32'(reg_add_o),      32'd2);
    next();
    slave(1'b0, 32'h0, 1'b0);
    #1;
    check("rsta_rv",     32'(data_r_valid_o), 32'd1);
    check("rsta_rdata",  data_r_rdata_o,      32'h0BAD_F00D);
    check("rsta_opc",    32'(data_r_opc_o),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
